pico_fault_mem: RTL

PICO_FAULT_MEM -- requirements
Module: pico_fault_mem

---
 rtl/pico_fault_pkg.sv | 29 ++
 rtl/pico_fault_mem_if.sv | 20 ++
 rtl/pico_xorshift64.sv | 20 ++
 rtl/pico_fault_mem.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pico_fault_pkg.sv
// Shared types, defaults and the xorshift64 step for the fault-injecting
// PicoRV32 memory model.
package pico_fault_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        INJ_SINGLE    = 2'd0,
        INJ_DOUBLE    = 2'd1,
        INJ_TRANSIENT = 2'd2,
        INJ_NONE      = 2'd3
    } inj_mode_t;

    localparam logic [31:0] DEF_CTRL_ADDR = 32'h4000_0000;
    localparam logic [63:0] DEF_SEED      = 64'hDEAD_BEEF_1234_5678;

    function automatic logic [63:0] xorshift64_next(input logic [63:0] x);
        logic [63:0] v;
        v = x ^ (x << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

endpackage

// File: rtl/pico_fault_mem_if.sv
// PicoRV32 native memory bus: the core is the master, the memory the slave.
interface pico_fault_mem_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/pico_xorshift64.sv
// xorshift64 generator; advances one step per cycle while step is high.
module pico_xorshift64
    import pico_fault_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        step,
    input  logic [63:0] seed,
    output logic [63:0] state
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= seed;
        end else if (step) begin
            state <= xorshift64_next(state);
        end
    end

endmodule

// File: rtl/pico_fault_mem.sv
// Word-addressed memory for PicoRV32 with configurable wait states, a MISR
// control register and a periodic bit-flip fault injector.
//
// state   | meaning
// IDLE    | waiting for mem_valid; LATENCY=0 commits directly from here
// WAIT    | counting wait states; dropping mem_valid aborts the request
// RESP    | mem_ready high for exactly one cycle
module pico_fault_mem
    import pico_fault_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          LATENCY    = 0,
    parameter int          INJ_PERIOD = 1000,
    parameter logic [63:0] SEED       = DEF_SEED,
    parameter logic [31:0] CTRL_ADDR  = DEF_CTRL_ADDR
) (
    input  logic             clk,
    input  logic             resetn,
    pico_fault_mem_if.slave  bus,
    input  logic             inj_en,
    input  logic [1:0]       inj_mode,
    output logic             misr_en,
    output logic             inj_event,
    output logic [15:0]      inj_count
);

    localparam int          DEPTH       = 2 ** ADDR_W;
    localparam int          PICK_W      = ADDR_W + 5;
    localparam logic [23:0] PERIOD_LOAD = 24'(INJ_PERIOD - 1);
    localparam logic [15:0] WAIT_LOAD   = 16'(LATENCY - 1);

    logic [31:0]       mem_array [DEPTH];
    mem_state_t        state;
    logic [15:0]       wait_cnt;
    logic              ready_q;
    logic [31:0]       rdata_q;
    logic [23:0]       period_cnt;
    logic              t_armed;
    logic [4:0]        t_bit;
    logic [63:0]       rng_state;
    logic [PICK_W-1:0] rng_pick;
    inj_mode_t         mode;
    logic [ADDR_W-1:0] host_idx;
    logic [ADDR_W-1:0] inj_word;
    logic [4:0]        inj_bit;
    logic              ctrl_hit;
    logic              is_read;
    logic              commit;
    logic              host_we;
    logic              fire;
    logic              array_flip;
    logic [31:0]       flip_mask;
    logic [31:0]       old_word;
    logic [31:0]       host_merged;
    logic [31:0]       resp_word;

    assign mode     = inj_mode_t'(inj_mode);
    assign ctrl_hit = (bus.mem_addr == CTRL_ADDR);
    assign is_read  = (bus.mem_wstrb == 4'h0);
    assign host_idx = bus.mem_addr[ADDR_W+1:2];
    assign old_word = mem_array[host_idx];

    // Commit happens on the edge that enters RESP; gating with resetn keeps a
    // reset cycle from writing the array.
    assign commit = resetn && bus.mem_valid &&
                    (((state == ST_IDLE) && (LATENCY == 0)) ||
                     ((state == ST_WAIT) && (wait_cnt == 16'd0)));
    assign host_we = commit && !ctrl_hit && !is_read;

    assign fire       = resetn && inj_en && (mode != INJ_NONE) && (period_cnt == 24'd0);
    assign array_flip = fire && ((mode == INJ_SINGLE) || (mode == INJ_DOUBLE));

    // Target is taken from the advanced RNG value, the one the generator holds after this fire.
    assign rng_pick = PICK_W'(xorshift64_next(rng_state));
    assign inj_word = rng_pick[PICK_W-1:5];
    assign inj_bit  = rng_pick[4:0];

    pico_xorshift64 u_rng (
        .clk    (clk),
        .resetn (resetn),
        .step   (fire),
        .seed   (SEED),
        .state  (rng_state)
    );

    always_comb begin
        flip_mask          = 32'h0;
        flip_mask[inj_bit] = 1'b1;
        if (mode == INJ_DOUBLE) begin
            flip_mask[inj_bit + 5'd1] = 1'b1;
        end
    end

    always_comb begin
        host_merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_wstrb[i]) begin
                host_merged[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            end
        end
        if (array_flip && (inj_word == host_idx)) begin
            host_merged = host_merged ^ flip_mask;
        end
    end

    always_comb begin
        resp_word = ctrl_hit ? {31'b0, misr_en} : old_word;
        if (is_read && t_armed) begin
            resp_word[t_bit] = ~resp_word[t_bit];
        end
    end

    always_ff @(posedge clk) begin
        if (host_we) begin
            mem_array[host_idx] <= host_merged;
        end
        if (array_flip && !(host_we && (host_idx == inj_word))) begin
            mem_array[inj_word] <= mem_array[inj_word] ^ flip_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            wait_cnt <= 16'd0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
            misr_en  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (commit) begin
                state   <= ST_RESP;
                ready_q <= 1'b1;
                rdata_q <= resp_word;
                if (ctrl_hit && (bus.mem_wstrb == 4'hF)) begin
                    misr_en <= (bus.mem_wdata == 32'h1);
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.mem_valid) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                    ST_WAIT: begin
                        if (!bus.mem_valid) begin
                            state <= ST_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt - 16'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            period_cnt <= PERIOD_LOAD;
            inj_event  <= 1'b0;
            inj_count  <= 16'h0;
            t_armed    <= 1'b0;
            t_bit      <= 5'd0;
        end else begin
            inj_event <= fire;
            if (inj_en && (mode != INJ_NONE)) begin
                period_cnt <= (period_cnt == 24'd0) ? PERIOD_LOAD : period_cnt - 24'd1;
            end
            if (fire && (inj_count != 16'hFFFF)) begin
                inj_count <= inj_count + 16'd1;
            end
            if (fire && (mode == INJ_TRANSIENT)) begin
                t_armed <= 1'b1;
                t_bit   <= inj_bit;
            end else if (commit && is_read && t_armed) begin
                t_armed <= 1'b0;
            end
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

endmodule
